// File: rtl/cla_pkg.sv
// Shared types and defaults for the multi-precision add controller and its word adder.
package cla_pkg;

    typedef enum logic [1:0] {IDLE, SUMA, FIN} estado_t;

    localparam int unsigned ANCHO_DEF    = 8;
    localparam int unsigned PALABRAS_DEF = 4;

endpackage

// File: rtl/cla.sv
// Ancho-bit carry-lookahead adder; S carries the extra carry bit at S[Ancho].
module cla
    import cla_pkg::*;
#(
    parameter int unsigned Ancho = ANCHO_DEF
) (
    input  logic             clk,
    input  logic [Ancho-1:0] A,
    input  logic [Ancho-1:0] B,
    input  logic             Cin,
    output logic [Ancho:0]   S,
    output logic             Cout,
    output logic             Overflow
);

    logic [Ancho-1:0] g;
    logic [Ancho-1:0] p;
    logic [Ancho:0]   c;

    always_comb begin
        g    = A & B;
        p    = A ^ B;
        c    = '0;
        c[0] = Cin;
        for (int i = 0; i < Ancho; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        S        = {c[Ancho], p ^ c[Ancho-1:0]};
        Cout     = c[Ancho];
        Overflow = c[Ancho] ^ c[Ancho-1];
    end

    // Guards the generate/propagate network against the plain arithmetic sum.
    assert property (@(posedge clk) S == ({1'b0, A} + {1'b0, B} + {{Ancho{1'b0}}, Cin}));

endmodule

// File: rtl/cla_secuenciador.sv
// Multi-precision adder: one Ancho-bit word per cycle, LSW first, over a shared cla instance.
module cla_secuenciador
    import cla_pkg::*;
#(
    parameter int unsigned Ancho    = ANCHO_DEF,
    parameter int unsigned Palabras = PALABRAS_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [Ancho*Palabras-1:0] A,
    input  logic [Ancho*Palabras-1:0] B,
    input  logic                      Cin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [Ancho*Palabras-1:0] S,
    output logic                      Cout,
    output logic                      Overflow,
    output logic                      busy
);

    localparam int unsigned W  = Ancho * Palabras;
    localparam int unsigned KW = $clog2(Palabras);
    localparam logic [KW-1:0] KUlt = KW'(Palabras - 1);

    estado_t        estado;
    logic [KW-1:0]  k;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   res;
    logic           carry;
    logic           ovf;

    logic [Ancho-1:0] a_pal;
    logic [Ancho-1:0] b_pal;
    logic [Ancho:0]   suma;
    logic             cout_unused;
    logic             ovf_unused;

    assign a_pal = a_reg[k*Ancho +: Ancho];
    assign b_pal = b_reg[k*Ancho +: Ancho];

    cla #(
        .Ancho(Ancho)
    ) u_cla (
        .clk     (clk),
        .A       (a_pal),
        .B       (b_pal),
        .Cin     (carry),
        .S       (suma),
        .Cout    (cout_unused),
        .Overflow(ovf_unused)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado    <= IDLE;
            k         <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            res       <= '0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (estado)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= A;
                        b_reg    <= B;
                        carry    <= Cin;
                        k        <= '0;
                        res      <= '0;
                        ovf      <= 1'b0;
                        estado   <= SUMA;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SUMA: begin
                    res[k*Ancho +: Ancho] <= suma[Ancho-1:0];
                    carry                 <= suma[Ancho];
                    k                     <= k + 1'b1;
                    if (k == KUlt) begin
                        // Sign of the sum is the MSB of the word being written now.
                        ovf       <= (a_reg[W-1] == b_reg[W-1]) && (suma[Ancho-1] != a_reg[W-1]);
                        estado    <= FIN;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                FIN: begin
                    if (out_ready) begin
                        estado    <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    estado    <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign S        = res;
    assign Cout     = carry;
    assign Overflow = ovf;

endmodule

// File: tb/tb_cla_secuenciador.sv
// Self-checking bench: directed literal cases plus random traffic against a protocol-level model.
module tb_cla_secuenciador;

    localparam int ANCHO    = 8;
    localparam int PALABRAS = 4;
    localparam int W        = ANCHO * PALABRAS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] S;
    logic         Cout;
    logic         Overflow;
    logic         busy;

    always #5 clk = ~clk;

    cla_secuenciador #(
        .Ancho(ANCHO),
        .Palabras(PALABRAS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .S        (S),
        .Cout     (Cout),
        .Overflow (Overflow),
        .busy     (busy)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // {overflow, carry-out, sum} of a full-width signed/unsigned add.
    function automatic logic [W+1:0] full_add(input logic [W-1:0] a, b, input logic c);
        logic [W:0] t;
        t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        return {(a[W-1] == b[W-1]) && (t[W-1] != a[W-1]), t};
    endfunction

    // Protocol model: idle / working for Palabras edges / holding a result.
    logic         m_started = 1'b0;
    logic         m_job = 1'b0;
    logic         m_res = 1'b0;
    logic         m_clean = 1'b0;
    int           m_cnt = 0;
    logic [W-1:0] m_s = '0;
    logic         m_c = 1'b0;
    logic         m_o = 1'b0;

    always @(posedge clk) begin
        m_started <= 1'b1;
        if (!rst_n) begin
            m_job   <= 1'b0;
            m_res   <= 1'b0;
            m_clean <= 1'b1;
            m_s     <= '0;
            m_c     <= 1'b0;
            m_o     <= 1'b0;
        end else if (m_job) begin
            if (m_cnt == 1) begin
                m_job <= 1'b0;
                m_res <= 1'b1;
            end
            m_cnt <= m_cnt - 1;
        end else if (m_res) begin
            if (out_ready) m_res <= 1'b0;
        end else if (in_valid) begin
            m_job             <= 1'b1;
            m_clean           <= 1'b0;
            m_cnt             <= PALABRAS;
            {m_o, m_c, m_s}   <= full_add(A, B, Cin);
        end
    end

    int   cyc = 0;
    logic b2b_on = 1'b0;
    int   b2b_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_started) begin
            chk("in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, !m_job && !m_res});
            chk("busy", {{W{1'b0}}, busy}, {{W{1'b0}}, m_job});
            chk("out_valid", {{W{1'b0}}, out_valid}, {{W{1'b0}}, m_res});
            if (m_res || m_clean) begin
                chk("model_S", {1'b0, S}, {1'b0, m_s});
                chk("model_Cout", {{W{1'b0}}, Cout}, {{W{1'b0}}, m_c});
                chk("model_Overflow", {{W{1'b0}}, Overflow}, {{W{1'b0}}, m_o});
            end
            if (b2b_on && out_valid) b2b_q.push_back(cyc);
        end
    end

    // Caller is #1 after a rising edge; returns #1 after the result-release edge.
    task automatic run_op(input logic [W-1:0] a, b, input logic c,
                          input logic [W-1:0] es, input logic ec, eo, input int hold);
        int n;
        int lat;
        A = a; B = b; Cin = c; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_wait", {{W{1'b0}}, n < 20}, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency", (W+1)'(lat), (W+1)'(PALABRAS));
        chk("lit_S", {1'b0, S}, {1'b0, es});
        chk("lit_Cout", {{W{1'b0}}, Cout}, {{W{1'b0}}, ec});
        chk("lit_Overflow", {{W{1'b0}}, Overflow}, {{W{1'b0}}, eo});
        for (int i = 0; i < hold; i++) begin
            A = $urandom; B = $urandom; in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("hold_S", {1'b0, S}, {1'b0, es});
            chk("hold_Cout", {{W{1'b0}}, Cout}, {{W{1'b0}}, ec});
            chk("hold_Overflow", {{W{1'b0}}, Overflow}, {{W{1'b0}}, eo});
            chk("hold_in_ready", {{W{1'b0}}, in_ready}, 0);
            chk("hold_out_valid", {{W{1'b0}}, out_valid}, 1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_out_valid", {{W{1'b0}}, out_valid}, 0);
        chk("release_in_ready", {{W{1'b0}}, in_ready}, 1);
    endtask

    initial begin
        logic [W-1:0] pa[3];
        logic [W-1:0] pb[3];
        int n;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", {{W{1'b0}}, in_ready}, 1);
        chk("reset_out_valid", {{W{1'b0}}, out_valid}, 0);
        chk("reset_busy", {{W{1'b0}}, busy}, 0);
        chk("reset_S", {1'b0, S}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 0);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 0);
        run_op(32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0, 0);
        run_op(32'h0F0F0F0F, 32'h01010101, 1'b0, 32'h10101010, 1'b0, 1'b0, 5);

        // Reset while word 2 is next to be processed.
        A = 32'hDEADBEEF; B = 32'h12345678; Cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_in_ready", {{W{1'b0}}, in_ready}, 1);
        chk("midrst_busy", {{W{1'b0}}, busy}, 0);
        chk("midrst_out_valid", {{W{1'b0}}, out_valid}, 0);
        chk("midrst_S", {1'b0, S}, 0);
        run_op(32'h00000005, 32'h00000003, 1'b0, 32'h00000008, 1'b0, 1'b0, 0);

        // Back-to-back with in_valid and out_ready held high.
        pa[0] = 32'h00000001; pb[0] = 32'h00000002;
        pa[1] = 32'h80000000; pb[1] = 32'h80000000;
        pa[2] = 32'hA5A5A5A5; pb[2] = 32'h5A5A5A5B;
        b2b_on = 1'b1; in_valid = 1'b1; out_ready = 1'b1; Cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            A = pa[i]; B = pb[i];
            n = 0;
            while (!in_ready && n < 20) begin
                @(negedge clk); n++;
            end
            chk("b2b_accept_wait", {{W{1'b0}}, n < 20}, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        b2b_on = 1'b0;
        out_ready = 1'b0;
        chk("b2b_count", (W+1)'(b2b_q.size()), 3);
        if (b2b_q.size() == 3) begin
            chk("b2b_gap1", (W+1)'(b2b_q[1] - b2b_q[0]), 6);
            chk("b2b_gap2", (W+1)'(b2b_q[2] - b2b_q[1]), 6);
        end

        for (int i = 0; i < 600; i++) begin
            A         = $urandom;
            B         = $urandom;
            Cin       = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 2) != 0);
            rst_n     = ($urandom_range(0, 99) != 0);
            @(posedge clk); #1;
        end
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
